// File: rtl/binary_ascii_pkg.sv
// Shared constants, encodings and the digit-count helper for the binary-to-ASCII converter.
// Import this package in every module of the converter.
package binary_ascii_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        JUST_LEFT  = 2'd0,
        JUST_RIGHT = 2'd1,
        JUST_ZERO  = 2'd2,
        JUST_ALT   = 2'd3
    } justify_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_e;

    // Number of decimal digits needed to print 2^width-1.
    function automatic int calc_digits(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        while (v != 0) begin
            n++;
            v = v / 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/ascii_formatter.sv
// Combinational formatter: packed BCD digits, sign and justify mode in, fixed-width
// ASCII string out, with the most significant character in the top byte.
module ascii_formatter
    import binary_ascii_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int CHARS  = DIGITS + 1
) (
    input  logic [4*DIGITS-1:0] bcd,
    input  logic                neg,
    input  logic [1:0]          justify,
    output logic [8*CHARS-1:0]  str
);

    int         nsig;
    int         negi;
    int         len;
    int         off;
    int         rel;
    int         didx;
    logic [7:0] ch;

    always_comb begin
        nsig = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) nsig = i + 1;
        end
        negi = neg ? 1 : 0;
        len  = nsig + negi;
        off  = (justify == JUST_RIGHT) ? (CHARS - len) : 0;
        str  = '0;
        rel  = 0;
        didx = 0;
        ch   = ASCII_SPACE;
        // p counts character positions from the top (most significant) end
        for (int p = 0; p < CHARS; p++) begin
            ch   = ASCII_SPACE;
            rel  = p - off;
            didx = 0;
            if (justify == JUST_ZERO) begin
                if (p == 0) begin
                    ch = neg ? ASCII_MINUS : ASCII_SPACE;
                end else begin
                    didx = DIGITS - p;
                    ch   = ASCII_ZERO + {4'd0, bcd[4*didx +: 4]};
                end
            end else if (rel >= 0 && rel < len) begin
                if (neg && rel == 0) begin
                    ch = ASCII_MINUS;
                end else begin
                    didx = nsig - 1 - (rel - negi);
                    ch   = ASCII_ZERO + {4'd0, bcd[4*didx +: 4]};
                end
            end
            str[8*(CHARS-1-p) +: 8] = ch;
        end
    end

endmodule

// File: rtl/binary_to_ascii_n.sv
// Sequential binary-to-decimal-ASCII converter: double-dabble over WIDTH cycles, then one
// formatting cycle. Handshake: ifStart is sampled only while idle; ifBusy spans the job;
// ifDone pulses for one cycle when asciiNum is updated.
module binary_to_ascii_n
    import binary_ascii_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = calc_digits(WIDTH),
    parameter int CHARS  = DIGITS + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ifStart,
    input  logic [WIDTH-1:0]     binaryNum,
    input  logic                 ifSigned,
    input  logic [1:0]           justify,
    output logic [8*CHARS-1:0]   asciiNum,
    output logic                 ifDone,
    output logic                 ifBusy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = 6;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [1:0]           just_q, just_d;
    logic [8*CHARS-1:0]   ascii_q, ascii_d, fmt_str;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            just_q  <= 2'd0;
            ascii_q <= {CHARS{ASCII_SPACE}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            just_q  <= just_d;
            ascii_q <= ascii_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ifStart) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FORMAT;
            ST_FORMAT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Double-dabble correction: any digit of 5 or more would overflow once doubled
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        just_d  = just_q;
        ascii_d = ascii_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (ifStart) begin
                    neg_d  = ifSigned & binaryNum[WIDTH-1];
                    // Negating the most negative value wraps to itself, which is the correct magnitude
                    mag_d  = neg_d ? ((~binaryNum) + WIDTH'(1)) : binaryNum;
                    just_d = justify;
                    bcd_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
            end
            ST_FORMAT: begin
                ascii_d = fmt_str;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    ascii_formatter #(
        .DIGITS (DIGITS),
        .CHARS  (CHARS)
    ) u_formatter (
        .bcd     (bcd_q),
        .neg     (neg_q),
        .justify (just_q),
        .str     (fmt_str)
    );

    assign asciiNum = ascii_q;
    assign ifDone   = done_q;
    assign ifBusy   = busy_q;

endmodule

// File: tb/tb_binary_to_ascii_n.sv
// Directed plus random bench for binary_to_ascii_n at WIDTH=8 and WIDTH=16, with a
// queue-based scoreboard checking string value and ifDone timing.
module tb_binary_to_ascii_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, sgn8, done8, busy8;
    logic [7:0]  num8;
    logic [1:0]  just8;
    logic [31:0] ascii8;
    logic        start16, sgn16, done16, busy16;
    logic [15:0] num16;
    logic [1:0]  just16;
    logic [47:0] ascii16;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp8_q[$];
    int          cyc8_q[$];
    logic [47:0] exp16_q[$];
    int          cyc16_q[$];

    binary_to_ascii_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ifStart(start8), .binaryNum(num8), .ifSigned(sgn8),
        .justify(just8), .asciiNum(ascii8), .ifDone(done8), .ifBusy(busy8)
    );

    binary_to_ascii_n #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .ifStart(start16), .binaryNum(num16), .ifSigned(sgn16),
        .justify(just16), .asciiNum(ascii16), .ifDone(done16), .ifBusy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: decimal digits by repeated division
    function automatic logic [47:0] model(input int w, input logic [15:0] v, input logic s,
                                          input logic [1:0] j);
        int          nd;
        logic [31:0] t, mag;
        logic        neg;
        logic [7:0]  txt[$];
        logic [47:0] r;
        nd  = (w == 8) ? 3 : 5;
        neg = s && v[w-1];
        mag = neg ? ((32'd1 << w) - 32'(v)) : 32'(v);
        t   = mag;
        if (j == 2'd2) begin
            for (int i = 0; i < nd; i++) begin
                txt.push_front(8'h30 + 8'(t % 10));
                t = t / 10;
            end
            txt.push_front(neg ? 8'h2D : 8'h20);
        end else begin
            do begin
                txt.push_front(8'h30 + 8'(t % 10));
                t = t / 10;
            end while (t != 0);
            if (neg) txt.push_front(8'h2D);
            while (txt.size() < nd + 1) begin
                if (j == 2'd1) txt.push_front(8'h20);
                else txt.push_back(8'h20);
            end
        end
        r = '0;
        foreach (txt[i]) r = {r[39:0], txt[i]};
        return r;
    endfunction

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                check("done8_unexpected", 64'(done8), 64'd0);
            end else begin
                check("ascii8", 64'(ascii8), 64'(exp8_q.pop_front()));
                check("latency8", 64'(cyc), 64'(cyc8_q.pop_front()));
                check("busy8_at_done", 64'(busy8), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (exp16_q.size() == 0) begin
                check("done16_unexpected", 64'(done16), 64'd0);
            end else begin
                check("ascii16", 64'(ascii16), 64'(exp16_q.pop_front()));
                check("latency16", 64'(cyc), 64'(cyc16_q.pop_front()));
                check("busy16_at_done", 64'(busy16), 64'd0);
            end
        end
    end

    task automatic go8(input logic [7:0] v, input logic s, input logic [1:0] j,
                       input logic [31:0] e);
        @(negedge clk);
        num8   = v;
        sgn8   = s;
        just8  = j;
        start8 = 1'b1;
        exp8_q.push_back(e);
        cyc8_q.push_back(cyc + 10);
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_after_accept", 64'(busy8), 64'd1);
    endtask

    task automatic go16(input logic [15:0] v, input logic s, input logic [1:0] j,
                        input logic [47:0] e);
        @(negedge clk);
        num16   = v;
        sgn16   = s;
        just16  = j;
        start16 = 1'b1;
        exp16_q.push_back(e);
        cyc16_q.push_back(cyc + 18);
        @(negedge clk);
        start16 = 1'b0;
        check("busy16_after_accept", 64'(busy16), 64'd1);
    endtask

    task automatic wait8();
        int k = 0;
        while (exp8_q.size() != 0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("timeout8", 64'(exp8_q.size()), 64'd0);
        exp8_q.delete();
        cyc8_q.delete();
    endtask

    task automatic wait16();
        int k = 0;
        while (exp16_q.size() != 0 && k < 80) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("timeout16", 64'(exp16_q.size()), 64'd0);
        exp16_q.delete();
        cyc16_q.delete();
    endtask

    logic [7:0]  tab_v[6] = '{8'hD6, 8'd0, 8'd0, 8'd7, 8'hFB, 8'd100};
    logic        tab_s[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  tab_j[6] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
    logic [31:0] tab_e[6] = '{32'h2D343220, 32'h30202020, 32'h20202030,
                              32'h20303037, 32'h20202D35, 32'h31303020};

    initial begin
        logic [15:0] rv;
        logic        rs;
        logic [1:0]  rj;
        logic [47:0] m;

        rst = 1'b1;
        start8 = 1'b0;  sgn8 = 1'b0;  num8 = '0;  just8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; num16 = '0; just16 = '0;
        #1;
        check("reset_ascii8", 64'(ascii8), 64'h20202020);
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_ascii16", 64'(ascii16), 64'h202020202020);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        go8(8'd5, 1'b0, 2'd0, 32'h35202020);
        wait8();

        // Request arriving mid-conversion must be dropped
        go8(8'd255, 1'b0, 2'd1, 32'h20323535);
        repeat (3) @(negedge clk);
        num8 = 8'd7;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait8();
        repeat (12) @(negedge clk);

        go8(8'h80, 1'b1, 2'd2, 32'h2D313238);
        wait8();
        go8(8'hFF, 1'b1, 2'd0, 32'h2D312020);
        wait8();

        for (int i = 0; i < 6; i++) begin
            go8(tab_v[i], tab_s[i], tab_j[i], tab_e[i]);
            wait8();
        end

        go16(16'd65535, 1'b0, 2'd0, 48'h363535333520);
        wait16();
        go16(16'd0, 1'b0, 2'd2, 48'h203030303030);
        wait16();
        go16(16'h8000, 1'b1, 2'd1, 48'h2D3332373638);
        wait16();

        for (int i = 0; i < 6; i++) begin
            rv = 16'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rj = 2'($urandom_range(0, 3));
            m  = model(8, rv, rs, rj);
            go8(rv[7:0], rs, rj, m[31:0]);
            wait8();
            rv = 16'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            rj = 2'($urandom_range(0, 3));
            go16(rv, rs, rj, model(16, rv, rs, rj));
            wait16();
        end

        // Reset in the middle of shifting abandons the job
        go8(8'd200, 1'b0, 2'd0, 32'h32303020);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        exp8_q.delete();
        cyc8_q.delete();
        #1;
        check("midreset_busy8", 64'(busy8), 64'd0);
        check("midreset_done8", 64'(done8), 64'd0);
        check("midreset_ascii8", 64'(ascii8), 64'h20202020);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        go8(8'd123, 1'b0, 2'd1, 32'h20313233);
        wait8();

        // ifStart held high: a new job is accepted on the edge that ends the ifDone cycle
        @(negedge clk);
        num8   = 8'd9;
        sgn8   = 1'b0;
        just8  = 2'd0;
        start8 = 1'b1;
        exp8_q.push_back(32'h39202020);
        cyc8_q.push_back(cyc + 10);
        @(negedge clk);
        num8  = 8'd77;
        just8 = 2'd1;
        repeat (9) @(negedge clk);
        check("done8_b2b_first", 64'(done8), 64'd1);
        exp8_q.push_back(32'h20203737);
        cyc8_q.push_back(cyc + 10);
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_b2b_second", 64'(busy8), 64'd1);
        wait8();
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
